// File: rtl/retire_trace_pipe.sv
// retire_trace_pipe
//   Shadow pipeline that carries per-instruction trace fields (pc, instr,
//   rs/rt/rd, format) from issue to write-back alongside the core pipeline.
//   On retirement, the last stage becomes a trace record tagged with a
//   sequence number and is pushed into a show-ahead FIFO. A checker drains
//   the FIFO through a valid/ready handshake.
//
//   Optional feature macro: RETIRE_TRACE_TIMESTAMP_EN
//     defined   -> free-running 32-bit cycle counter; each record stores the
//                  counter value at its retire edge, presented on out_cycle
//     undefined -> no counter and no out_cycle port
//
// Ports
//   clk, reset                 clock (rising edge), async active-low reset
//   in_valid, in_pc, in_instr  fetch-side instruction presented this cycle
//   in_rs, in_rt, in_rd        decoded register indices
//   in_fmt                     0=R 1=I 2=J 3=illegal
//   stall, flush               hold all stages / kill the FLUSH_DEPTH youngest
//   retire                     core retired the write-back instruction
//   out_valid, out_ready       FIFO head handshake
//   out_pc .. out_seq          head record (zero while the FIFO is empty)
//   fifo_count                 registered occupancy
//   err_overflow/orphan/fmt    sticky error flags, cleared only by reset
module retire_trace_pipe #(
  parameter int STAGES      = 4,
  parameter int DATA_W      = 32,
  parameter int FLUSH_DEPTH = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int SEQ_W       = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [DATA_W-1:0]             in_pc,
  input  logic [DATA_W-1:0]             in_instr,
  input  logic [4:0]                    in_rs,
  input  logic [4:0]                    in_rt,
  input  logic [4:0]                    in_rd,
  input  logic [1:0]                    in_fmt,
  input  logic                          stall,
  input  logic                          flush,
  input  logic                          retire,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_pc,
  output logic [DATA_W-1:0]             out_instr,
  output logic [4:0]                    out_rs,
  output logic [4:0]                    out_rt,
  output logic [4:0]                    out_rd,
  output logic [1:0]                    out_fmt,
  output logic [SEQ_W-1:0]              out_seq,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_overflow,
  output logic                          err_orphan,
  output logic                          err_fmt
`ifdef RETIRE_TRACE_TIMESTAMP_EN
  ,
  output logic [31:0]                   out_cycle
`endif
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int LAST = STAGES - 1;

  // Shadow stages
  logic [STAGES-1:0] st_valid_r;
  logic [DATA_W-1:0] st_pc_r    [STAGES];
  logic [DATA_W-1:0] st_instr_r [STAGES];
  logic [4:0]        st_rs_r    [STAGES];
  logic [4:0]        st_rt_r    [STAGES];
  logic [4:0]        st_rd_r    [STAGES];
  logic [1:0]        st_fmt_r   [STAGES];

  // Record FIFO storage and control
  logic [DATA_W-1:0] mem_pc_r    [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_instr_r [FIFO_DEPTH];
  logic [4:0]        mem_rs_r    [FIFO_DEPTH];
  logic [4:0]        mem_rt_r    [FIFO_DEPTH];
  logic [4:0]        mem_rd_r    [FIFO_DEPTH];
  logic [1:0]        mem_fmt_r   [FIFO_DEPTH];
  logic [SEQ_W-1:0]  mem_seq_r   [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;
  logic [SEQ_W-1:0]  seq_r;
  logic              err_overflow_r;
  logic              err_orphan_r;
  logic              err_fmt_r;

`ifdef RETIRE_TRACE_TIMESTAMP_EN
  logic [31:0]       cycle_r;
  logic [31:0]       mem_cyc_r [FIFO_DEPTH];
`endif

  logic do_retire_s;
  logic orphan_s;
  logic empty_s;
  logic full_s;
  logic pop_s;
  logic push_s;
  logic drop_s;

  // Retire qualification and FIFO push/pop decisions
  always_comb begin
    do_retire_s = retire & st_valid_r[LAST];
    orphan_s    = retire & ~st_valid_r[LAST];
    empty_s     = (count_r == CW'(0));
    full_s      = (count_r == CW'(FIFO_DEPTH));
    pop_s       = ~empty_s & out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    push_s      = do_retire_s & (~full_s | pop_s);
    drop_s      = do_retire_s & full_s & ~pop_s;
  end

  // Shadow stage shift / hold with flush kill and retire-under-stall clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_valid_r <= '0;
      for (int k = 0; k < STAGES; k++) begin
        st_pc_r[k]    <= '0;
        st_instr_r[k] <= '0;
        st_rs_r[k]    <= 5'd0;
        st_rt_r[k]    <= 5'd0;
        st_rd_r[k]    <= 5'd0;
        st_fmt_r[k]   <= 2'd0;
      end
    end else if (!stall) begin
      // Flush kills the freshly captured stage 0, so it wins over in_valid.
      st_valid_r[0] <= in_valid & ~flush;
      st_pc_r[0]    <= in_pc;
      st_instr_r[0] <= in_instr;
      st_rs_r[0]    <= in_rs;
      st_rt_r[0]    <= in_rt;
      st_rd_r[0]    <= in_rd;
      st_fmt_r[0]   <= in_fmt;
      for (int k = 1; k < STAGES; k++) begin
        st_valid_r[k] <= st_valid_r[k-1] & !(flush && (k < FLUSH_DEPTH));
        st_pc_r[k]    <= st_pc_r[k-1];
        st_instr_r[k] <= st_instr_r[k-1];
        st_rs_r[k]    <= st_rs_r[k-1];
        st_rt_r[k]    <= st_rt_r[k-1];
        st_rd_r[k]    <= st_rd_r[k-1];
        st_fmt_r[k]   <= st_fmt_r[k-1];
      end
    end else begin
      // Held contents: only valid bits may change. Clearing the last stage on
      // retire keeps one entry from retiring twice across a long stall.
      for (int k = 0; k < STAGES; k++) begin
        if (flush && (k < FLUSH_DEPTH)) begin
          st_valid_r[k] <= 1'b0;
        end else if ((k == LAST) && do_retire_s) begin
          st_valid_r[k] <= 1'b0;
        end else begin
          st_valid_r[k] <= st_valid_r[k];
        end
      end
    end
  end

  // Record storage write on push
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_pc_r[i]    <= '0;
        mem_instr_r[i] <= '0;
        mem_rs_r[i]    <= 5'd0;
        mem_rt_r[i]    <= 5'd0;
        mem_rd_r[i]    <= 5'd0;
        mem_fmt_r[i]   <= 2'd0;
        mem_seq_r[i]   <= '0;
`ifdef RETIRE_TRACE_TIMESTAMP_EN
        mem_cyc_r[i]   <= 32'd0;
`endif
      end
    end else if (push_s) begin
      mem_pc_r[wr_ptr_r]    <= st_pc_r[LAST];
      mem_instr_r[wr_ptr_r] <= st_instr_r[LAST];
      mem_rs_r[wr_ptr_r]    <= st_rs_r[LAST];
      mem_rt_r[wr_ptr_r]    <= st_rt_r[LAST];
      mem_rd_r[wr_ptr_r]    <= st_rd_r[LAST];
      mem_fmt_r[wr_ptr_r]   <= st_fmt_r[LAST];
      mem_seq_r[wr_ptr_r]   <= seq_r;
`ifdef RETIRE_TRACE_TIMESTAMP_EN
      mem_cyc_r[wr_ptr_r]   <= cycle_r;
`endif
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sequence number and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_r          <= '0;
      err_overflow_r <= 1'b0;
      err_orphan_r   <= 1'b0;
      err_fmt_r      <= 1'b0;
    end else begin
      // Dropped records still consume a number so the consumer sees the gap.
      if (do_retire_s) seq_r <= seq_r + SEQ_W'(1);
      if (drop_s)      err_overflow_r <= 1'b1;
      if (orphan_s)    err_orphan_r   <= 1'b1;
      if (do_retire_s && (st_fmt_r[LAST] == 2'd3)) err_fmt_r <= 1'b1;
    end
  end

`ifdef RETIRE_TRACE_TIMESTAMP_EN
  // Free-running cycle counter used to timestamp records
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_r <= 32'd0;
    end else begin
      cycle_r <= cycle_r + 32'd1;
    end
  end
`endif

  // Show-ahead head presentation, forced to zero while empty
  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_instr = '0;
    out_rs    = 5'd0;
    out_rt    = 5'd0;
    out_rd    = 5'd0;
    out_fmt   = 2'd0;
    out_seq   = '0;
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    out_cycle = 32'd0;
`endif
    if (!empty_s) begin
      out_valid = 1'b1;
      out_pc    = mem_pc_r[rd_ptr_r];
      out_instr = mem_instr_r[rd_ptr_r];
      out_rs    = mem_rs_r[rd_ptr_r];
      out_rt    = mem_rt_r[rd_ptr_r];
      out_rd    = mem_rd_r[rd_ptr_r];
      out_fmt   = mem_fmt_r[rd_ptr_r];
      out_seq   = mem_seq_r[rd_ptr_r];
`ifdef RETIRE_TRACE_TIMESTAMP_EN
      out_cycle = mem_cyc_r[rd_ptr_r];
`endif
    end else begin
      out_valid = 1'b0;
    end
  end

  assign fifo_count   = count_r;
  assign err_overflow = err_overflow_r;
  assign err_orphan   = err_orphan_r;
  assign err_fmt      = err_fmt_r;

endmodule
